// File: rtl/debounce_pkg.sv
// Shared debounce definitions: FSM state encoding and the 1 ms default hold
// time at 50 MHz.
package debounce_pkg;

   typedef enum logic {
      DB_IDLE  = 1'b0,
      DB_COUNT = 1'b1
   } db_state_e;

   localparam int DB_STABLE_CNT_1MS = 50000;

endpackage

// File: rtl/debounce_sync_2ff.sv
// sync_2ff: two-flop synchroniser bringing one asynchronous bit into clk.
// Reusable wherever a single-bit crossing is needed.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= RST_VAL;
         s_q  <= RST_VAL;
      end else begin
         s1_q <= d;
         s_q  <= s1_q;
      end
   end

   assign q = s_q;

endmodule

// File: rtl/debounce.sv
// debounce: synchronises din, then publishes a new level only after it has held
// for STABLE_CNT cycles. Define DEBOUNCE_EDGE_EN to add rise/fall pulse outputs.
module debounce
   import debounce_pkg::*;
#(
   parameter int   STABLE_CNT = DB_STABLE_CNT_1MS,
   parameter int   CNT_W      = 16,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic busy
`ifdef DEBOUNCE_EDGE_EN
   ,
   output logic rise,
   output logic fall
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   if (STABLE_CNT < 2) begin : g_bad_stable_cnt
      $error("debounce: STABLE_CNT must be at least 2");
   end
   if ($clog2(STABLE_CNT) > CNT_W) begin : g_bad_cnt_w
      $error("debounce: CNT_W too narrow to hold STABLE_CNT-1");
   end

   logic             s;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;

   sync_2ff #(
      .RST_VAL (RST_VAL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DB_IDLE;
         cnt_q   <= '0;
         dout_q  <= RST_VAL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
      end
   end

   // Any sample that matches dout again throws the partial count away.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      case (state_q)
         DB_IDLE: begin
            if (s != dout_q) begin
               state_d = DB_COUNT;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         DB_COUNT: begin
            if (s == dout_q) begin
               state_d = DB_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               dout_d  = s;
               state_d = DB_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = DB_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign dout = dout_q;
   assign busy = (state_q == DB_COUNT);

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q;
   logic fall_q;

   // Pulses are loaded on the same edge that loads the new dout.
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= dout_d & ~dout_q;
         fall_q <= ~dout_d & dout_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`endif

endmodule
